// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// port (master 0) and a loader/debug port (master 1). Grants at most one
// transaction per cycle with round-robin fairness, supports a lock for atomic
// read-modify-write sequences, and returns registered load data one cycle later.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state_reg;
    logic              last_reg;      // most recently granted master
    logic [DATA_W-1:0] rdata_reg;     // shared load-data register
    logic [1:0]        rvalid_reg;    // per-master load-data valid pulse

    // Per-master views of the request side, indexed by master number
    logic [1:0] req_vec;
    logic [1:0] we_vec;
    logic [1:0] lock_vec;
    logic [1:0] gnt_vec;
    logic [1:0] load_acc;             // accepted load per master

    assign req_vec  = {m1_req,  m0_req};
    assign we_vec   = {m1_we,   m0_we};
    assign lock_vec = {m1_lock, m0_lock};

    // Combinational grant: owner only while locked, otherwise round-robin on contention
    always_comb begin
        gnt_vec = 2'b00;
        if (rst_n) begin
            case (state_reg)
                IDLE: begin
                    if (req_vec == 2'b11) begin
                        // Both asking: the master that was not served last wins
                        if (last_reg) begin
                            gnt_vec = 2'b01;
                        end else begin
                            gnt_vec = 2'b10;
                        end
                    end else begin
                        gnt_vec = req_vec;
                    end
                end
                OWN0:    gnt_vec = {1'b0, req_vec[0]};
                OWN1:    gnt_vec = {req_vec[1], 1'b0};
                default: gnt_vec = 2'b00;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign load_acc[gi] = gnt_vec[gi] & ~we_vec[gi];
        end
    endgenerate

    assign m0_gnt = gnt_vec[0];
    assign m1_gnt = gnt_vec[1];

    // Memory side follows the granted master, defaulting to master 0 when idle
    assign mem_address = gnt_vec[1] ? m1_addr  : m0_addr;
    assign mem_wdata   = gnt_vec[1] ? m1_wdata : m0_wdata;
    assign mem_w_en    = |(gnt_vec & we_vec);

    // Read-return outputs are held at their reset values while reset is asserted,
    // so a load accepted just before reset never shows a pulse or stale data.
    assign m0_rvalid = rvalid_reg[0] & rst_n;
    assign m1_rvalid = rvalid_reg[1] & rst_n;
    assign m0_rdata  = rst_n ? rdata_reg : '0;
    assign m1_rdata  = rst_n ? rdata_reg : '0;

    // Ownership FSM, round-robin pointer and load-return registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            last_reg   <= 1'b1;
            rdata_reg  <= '0;
            rvalid_reg <= 2'b00;
        end else begin
            rvalid_reg <= load_acc;
            if (|load_acc) begin
                rdata_reg <= mem_rdata;
            end

            if (gnt_vec[0]) begin
                last_reg  <= 1'b0;
                state_reg <= m0_lock ? OWN0 : IDLE;
            end else if (gnt_vec[1]) begin
                last_reg  <= 1'b1;
                state_reg <= m1_lock ? OWN1 : IDLE;
            end else begin
                // No transaction: an idle owner releases only when it also drops lock
                case (state_reg)
                    OWN0: if (!req_vec[0] && !lock_vec[0]) state_reg <= IDLE;
                    OWN1: if (!req_vec[1] && !lock_vec[1]) state_reg <= IDLE;
                    IDLE: state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level reference model and a response
// scoreboard consumed by an independent monitor.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              req   [2];
    logic              we    [2];
    logic              lock  [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];

    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_addr(addr[0]),
        .m0_wdata(wdata[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_addr(addr[1]),
        .m1_wdata(wdata[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_w_en(mem_w_en), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, write on rising edge
    logic [DATA_W-1:0] mem [64];
    logic              mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + 32'(i);
        end else if (mem_w_en) begin
            mem[mem_address[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_address[7:2]];

    // Reference model state
    typedef struct {
        int          m;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q [$];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rdata;
    int          own;      // 0 none, 1 master 0 owns, 2 master 1 owns
    int          last;
    int          last_g;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (own == 1) return req[0] ? 0 : -1;
        if (own == 2) return req[1] ? 1 : -1;
        if (req[0] && req[1]) return (last == 0) ? 1 : 0;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    // One clock cycle: check combinational outputs, take the edge, advance the model
    task automatic step();
        int g;
        int sel;
        logic exp_we;
        if (!rst_n) exp_q.delete();
        #1;
        g      = exp_grant();
        sel    = (g == 1) ? 1 : 0;
        exp_we = 1'b0;
        if (g >= 0) exp_we = we[g];
        check("m0_gnt", 32'(m0_gnt), 32'(g == 0));
        check("m1_gnt", 32'(m1_gnt), 32'(g == 1));
        check("mem_w_en", 32'(mem_w_en), 32'(exp_we));
        check("mem_address", mem_address, addr[sel]);
        check("mem_wdata", mem_wdata, wdata[sel]);
        check("m0_rdata", m0_rdata, rst_n ? exp_rdata : 32'h0);
        check("m1_rdata", m1_rdata, rst_n ? exp_rdata : 32'h0);
        @(posedge clk);
        last_g = -1;
        if (!rst_n) begin
            own       = 0;
            last      = 1;
            exp_rdata = 32'h0;
        end else if (g >= 0) begin
            last_g = g;
            last   = g;
            own    = lock[g] ? g + 1 : 0;
            if (we[g]) begin
                ref_mem[addr[g][7:2]] = wdata[g];
                $display("txn m%0d store addr=0x%08h data=0x%08h lock=%0d", g, addr[g], wdata[g], lock[g]);
            end else begin
                exp_rdata = ref_mem[addr[g][7:2]];
                exp_q.push_back('{g, exp_rdata});
                $display("txn m%0d load  addr=0x%08h data=0x%08h lock=%0d", g, addr[g], exp_rdata, lock[g]);
            end
        end else if (own != 0 && !req[own-1] && !lock[own-1]) begin
            own = 0;
        end
        #1;
    endtask

    // Monitor: every cycle, the head of the scoreboard (if any) must be on the read port
    always @(negedge clk) begin
        resp_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("m0_rvalid", 32'(m0_rvalid), 32'(e.m == 0));
                check("m1_rvalid", 32'(m1_rvalid), 32'(e.m == 1));
                check("resp_m0_rdata", m0_rdata, e.data);
                check("resp_m1_rdata", m1_rdata, e.data);
            end else begin
                check("m0_rvalid_idle", 32'(m0_rvalid), 32'h0);
                check("m1_rvalid_idle", 32'(m1_rvalid), 32'h0);
            end
        end
    end

    task automatic set_m(input int m, input bit r, input bit w, input bit l,
                         input logic [31:0] a, input logic [31:0] d);
        req[m]   = r;
        we[m]    = w;
        lock[m]  = l;
        addr[m]  = a;
        wdata[m] = d;
    endtask

    task automatic idle_all();
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_init  = 1'b1;
        own       = 0;
        last      = 1;
        last_g    = -1;
        exp_rdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 + 32'(i);
        idle_all();
        @(posedge clk);
        #1;
        step();
        step();
        mem_init = 1'b0;
        rst_n    = 1'b1;
        mon_en   = 1'b1;

        // Store then load from master 0
        set_m(0, 1, 1, 0, 32'h10, 32'hDEADBEEF); step();
        set_m(0, 1, 0, 0, 32'h10, 32'h0);        step();
        idle_all();                              step();

        // Sustained contention from reset: 0,1,0,1
        do_reset(1);
        set_m(0, 1, 0, 0, 32'h10, 32'h0);
        set_m(1, 1, 0, 0, 32'h14, 32'h0);
        for (int i = 0; i < 4; i++) step();
        idle_all(); step();

        // Master 1 locked load then unlocked store while master 0 waits
        do_reset(1);
        set_m(0, 1, 0, 0, 32'h0, 32'h0);   step();
        set_m(1, 1, 0, 1, 32'h20, 32'h0);  step();
        set_m(1, 1, 1, 0, 32'h20, 32'h77); step();
        set_m(1, 0, 0, 0, 32'h0, 32'h0);   step();
        idle_all(); step();

        // Lone store from master 1, then idle
        set_m(1, 1, 1, 0, 32'h20, 32'h5); step();
        idle_all(); step();

        // Reset during master 0 ownership with both masters requesting stores
        set_m(0, 1, 0, 1, 32'h8, 32'h0); step();
        set_m(0, 1, 1, 0, 32'h8, 32'h11);
        set_m(1, 1, 1, 0, 32'hC, 32'h22);
        do_reset(1);
        step();
        idle_all(); step();

        // Load accepted right before reset: no pulse, rdata cleared
        set_m(0, 1, 0, 0, 32'h4, 32'h0); step();
        idle_all();
        do_reset(1);
        step();

        // Random traffic with occasional locks and resets
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (last_g == m || !req[m]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        set_m(m, 1, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                              32'($urandom_range(0, 15)) << 2, $urandom);
                    end else begin
                        set_m(m, 0, 0, ($urandom_range(0, 3) == 0), 32'h0, 32'h0);
                    end
                end
            end
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        idle_all();
        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single-port data memory (32-bit words, combinational read, write on rising clock edge) between the CPU load/store port (master 0) and a loader/debug port (master 1). It grants at most one transaction per cycle, using round-robin fairness with an optional lock for atomic read-modify-write sequences. It drives the memory's write-enable, address and write-data inputs, and returns registered read data to the granted master one cycle later. It sits between the masters and the data memory.

## Interface
- ADDR_W, 32, byte address width passed to memory
- DATA_W, 32, data word width

- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- m0_req / m1_req  input  1  transaction request, held until granted
- m0_we / m1_we  input  1  1 = store, 0 = load
- m0_lock / m1_lock  input  1  keep ownership after this transaction
- m0_addr / m1_addr  input  ADDR_W  byte address, word-aligned by master
- m0_wdata / m1_wdata  input  DATA_W  store data
- m0_gnt / m1_gnt  output  1  combinational; transaction accepted at the edge where req&gnt=1
- m0_rvalid / m1_rvalid  output  1  load data valid, 1-cycle pulse
- m0_rdata / m1_rdata  output  DATA_W  registered load data
- mem_w_en  output  1  memory write enable
- mem_address  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory combinational read data

## Operation
- States:
  - IDLE: no owner.
  - OWN0: master 0 locked.
  - OWN1: master 1 locked.
- Round-robin pointer `last` records the most recently granted master. Reset value is 1, so master 0 wins the first contention.
- IDLE:
  - Only one req: grant that master.
  - Both req: grant the master ≠ `last`.
  - No req: no grant.
- OWNx:
  - Only master x can be granted, and only when mx_req=1.
  - The other master's req is ignored; its gnt stays 0.
- Transitions, evaluated at the edge:
  - A granted transaction with mx_lock=1 moves to (or stays in) OWNx.
  - A granted transaction with lock=0 returns to IDLE.
  - In OWNx, mx_req=0 with mx_lock=0 returns to IDLE.
  - In OWNx, mx_req=0 with mx_lock=1 stays in OWNx.
- `last` updates to the granted master on every accepted transaction.
- Memory mux:
  - mem_address and mem_wdata follow the granted master. With no grant, they follow master 0.
  - mem_w_en = granted & we. It is 0 with no grant.
- Loads: a granted load captures mem_rdata into a shared rdata register at the edge. It pulses mx_rvalid for the next cycle.
  - m0_rdata and m1_rdata both show the register value; only the owner's rvalid is high.
- Stores: the write is performed by memory at the accepting edge. No rvalid is generated.
- Address is passed unmodified. Word indexing and misalignment are outside this block.

## Timing
- Grant: combinational from req, state and `last`. Zero-cycle accept.
- Load latency: data and rvalid appear 1 cycle after the accepting edge. Back-to-back loads give rvalid on consecutive cycles.
- Store followed by a load to the same address on the next cycle returns the new data.
- Reset while rst_n=0:
  - gnt=0, mem_w_en=0 (forced combinationally, no memory writes).
  - At the edge: state=IDLE, `last`=1, rvalid=0, rdata=0.
- Reset mid-lock discards ownership. A load accepted on the edge before reset does not produce rvalid if rst_n is low at the next edge.
- Sustained contention with lock=0 alternates grants 0,1,0,1.
- A locked master may hold memory indefinitely; no timeout.

## Test plan
- Reset, then m0 stores 0xDEADBEEF to 0x10, then loads 0x10 → m0_gnt=1 each cycle; m0_rvalid=1 with m0_rdata=0xDEADBEEF one cycle after the load; m1_rvalid=0.
- m0_req and m1_req both held as loads for 4 cycles from reset → grants m0,m1,m0,m1; rvalid pulses alternate, each 1 cycle late.
- m1 load with m1_lock=1, then m1 store with lock=0, while m0_req is held throughout → m0_gnt=0 for both cycles; m0 is granted on the third cycle.
- m1 alone stores 0x5 to 0x20 → mem_w_en=1, mem_address=0x20, mem_wdata=0x5 in that cycle; next cycle, with no req, mem_w_en=0.
- In OWN0, assert rst_n=0 for 1 cycle with both req high → no gnt and no mem_w_en during reset; after release, m0 wins the first contention.
- m0 load accepted, then rst_n=0 at the next edge → m0_rvalid stays 0 and rdata=0.
